regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port integer register file with a built-in pending-write scoreboard, sitting in the decode stage between the instruction decoder and the issue logic. It offers NUM_RD combinational read ports with optional same-cycle write bypass and NUM_WR write ports with deterministic conflict resolution. Per register, it tracks a busy bit that issue sets on allocation and writeback clears, so the hazard logic can stall on outstanding producers. Register 0 is hardwired to zero and is never busy.

## Interface
- XLEN, 32: data width in bits.
- NUM_REGS, 32: number of architectural registers; power of two, ≥ 2.
- NUM_RD, 2: number of read ports.
- NUM_WR, 1: number of write ports.
- BYPASS, 1: 1 = a read of a register being written this cycle returns the write data; 0 = it returns the stored value.
- AW: localparam, $clog2(NUM_REGS).
- clk_i  in  1  clock; all state updates on rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- rd_addr_i  in  NUM_RD×AW  read addresses.
- rd_data_o  out  NUM_RD×XLEN  read data (combinational).
- rd_busy_o  out  NUM_RD  busy bit of the addressed register (combinational).
- wr_en_i  in  NUM_WR  write enables.
- wr_addr_i  in  NUM_WR×AW  write addresses.
- wr_data_i  in  NUM_WR×XLEN  write data.
- alloc_en_i  in  1  mark alloc_addr_i busy (instruction issued with rd).
- alloc_addr_i  in  AW  destination being allocated.
- flush_i  in  1  clear all busy bits (pipeline flush); data is kept.
- busy_vec_o  out  NUM_REGS  registered busy vector; bit 0 is always 0.

## Operation
- Reset (n_rst low, async): all registers = 0 and all busy bits = 0. In reset, rd_data_o = 0, rd_busy_o = 0 and busy_vec_o = 0. State holds at these values until the first rising edge after n_rst deasserts.
- Write: for each port p with wr_en_i[p]=1 and wr_addr_i[p]≠0, reg[wr_addr_i[p]] ← wr_data_i[p] at the rising edge. Writes to address 0 are discarded.
- Write conflict: if several ports target the same non-zero address in one cycle, the highest-indexed port wins. The other writes to that address are dropped.
- Read: if rd_addr_i = 0, data = 0. Otherwise, if BYPASS=1 and any enabled write port targets the same address this cycle, data = that port's wr_data_i, using the same highest-index rule. Otherwise data = the stored value.
- Busy update, in priority order per register r≠0 at each edge:
  1. flush_i = 1 → busy[r] ← 0. Flush overrides alloc and write.
  2. alloc_en_i = 1 and alloc_addr_i = r → busy[r] ← 1. Alloc wins over a same-cycle write to r, because the new producer supersedes the old one.
  3. Any enabled write port targets r → busy[r] ← 0.
  4. Otherwise busy[r] holds.
- Alloc to address 0 is ignored; busy[0] is constant 0.
- rd_busy_o[i] = busy[rd_addr_i[i]], taken from the registered state. It does not bypass same-cycle clears; the consumer stalls one extra cycle, which keeps the hazard path short.
- Read data and write data sizes are always XLEN; there is no width conversion.

## Timing
- Read latency 0 cycles (combinational from rd_addr_i and, if BYPASS=1, from the write inputs).
- Write latency 1 cycle: with BYPASS=0, data is visible on a read the cycle after wr_en_i.
- Busy set/clear latency 1 cycle: a busy bit is visible the cycle after alloc_en_i or the write.
- Reset asserted mid-operation clears data and busy bits immediately, regardless of in-flight writes.
- No handshake: every write and alloc is accepted in the cycle it is presented.

## Structure
- regfile_pkg holds the default XLEN, NUM_REGS, REG_ZERO = 0, and the typedef reg_addr_t = logic [AW-1:0]. Issue and hazard logic import the same package.
- One sub-module, regfile_scoreboard, holds the busy vector with its alloc/write/flush priority and drives busy_vec_o and rd_busy_o.
- The data array, write arbitration and bypass muxes stay in regfile_mp.

## Test plan
- Reset: hold n_rst=0, then release. Reading x1..x31 returns 0x0000_0000; busy_vec_o = 0.
- Write/read: write x5 = 0xDEAD_BEEF (BYPASS=0). The same-cycle read of x5 returns 0; the next cycle returns 0xDEAD_BEEF. A write of x0 = 0x1234 followed by a read of x0 returns 0.
- Bypass (BYPASS=1, NUM_WR=2): port 0 writes x7 = 0x11 and port 1 writes x7 = 0x22 in the same cycle. The same-cycle read returns 0x22, and next-cycle stored x7 = 0x22.
- Scoreboard: alloc x3 → busy_vec_o[3]=1 the next cycle. Writing x3 = 0x5 → busy clears the following cycle. Simultaneous alloc x3 and write x3 → busy stays 1 and data = 0x5.
- Flush: alloc x2, x4 and x9 over three cycles, then assert flush_i together with alloc x10. Next cycle busy_vec_o = 0 and data is unchanged.
- Async reset mid-operation: after writing x8 = 0xA5A5_A5A5 and allocating x8, pulse n_rst low between edges. Reads return 0 immediately and busy_vec_o = 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the decode-stage integer register file and its pending-write scoreboard.
// Issue and hazard logic import this package so register addressing stays consistent.
package regfile_pkg;

    localparam int REGFILE_XLEN     = 32;
    localparam int REGFILE_NUM_REGS = 32;
    localparam int REGFILE_AW       = $clog2(REGFILE_NUM_REGS);
    localparam int REG_ZERO         = 0;

    typedef logic [REGFILE_AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets a bit on allocation, writeback clears it, flush clears all.
// Register 0 never becomes busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = REGFILE_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                 clk_i,
    input  logic                 n_rst,
    input  logic [NUM_REGS-1:0]  i_wr_hit,
    input  logic                 i_alloc_en,
    input  logic [AW-1:0]        i_alloc_addr,
    input  logic                 i_flush,
    input  logic [NUM_RD*AW-1:0] i_rd_addr,
    output logic [NUM_REGS-1:0]  o_busy_vec,
    output logic [NUM_RD-1:0]    o_rd_busy
);

    logic [NUM_REGS-1:0] r_busy;

    // Priority per register: flush, then alloc (a newer producer supersedes), then writeback clear.
    always_ff @(posedge clk_i or negedge n_rst) begin
        if (!n_rst) begin
            r_busy <= '0;
        end else begin
            r_busy[0] <= 1'b0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (i_flush) begin
                    r_busy[r] <= 1'b0;
                end else if (i_alloc_en && (i_alloc_addr == AW'(r))) begin
                    r_busy[r] <= 1'b1;
                end else if (i_wr_hit[r]) begin
                    r_busy[r] <= 1'b0;
                end
            end
        end
    end

    assign o_busy_vec = r_busy;

    // Busy lookups use the registered state only; same-cycle clears are not bypassed.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_busy
        logic [AW-1:0] w_addr;
        assign w_addr       = i_rd_addr[i*AW +: AW];
        assign o_rd_busy[i] = r_busy[w_addr];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a busy scoreboard.
// Register 0 reads as zero; concurrent writes to one address resolve to the highest port.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN     = REGFILE_XLEN,
    parameter  int NUM_REGS = REGFILE_NUM_REGS,
    parameter  int NUM_RD   = 2,
    parameter  int NUM_WR   = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                   clk_i,
    input  logic                   n_rst,
    input  logic [NUM_RD*AW-1:0]   rd_addr_i,
    output logic [NUM_RD*XLEN-1:0] rd_data_o,
    output logic [NUM_RD-1:0]      rd_busy_o,
    input  logic [NUM_WR-1:0]      wr_en_i,
    input  logic [NUM_WR*AW-1:0]   wr_addr_i,
    input  logic [NUM_WR*XLEN-1:0] wr_data_i,
    input  logic                   alloc_en_i,
    input  logic [AW-1:0]          alloc_addr_i,
    input  logic                   flush_i,
    output logic [NUM_REGS-1:0]    busy_vec_o
);

    logic [XLEN-1:0]     r_regs    [NUM_REGS];
    logic [NUM_REGS-1:0] w_wr_hit;
    logic [XLEN-1:0]     w_wr_data [NUM_REGS];

    // Later ports overwrite earlier ones, so the highest-indexed writer wins per address.
    always_comb begin
        w_wr_hit = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_wr_data[r] = '0;
        end
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en_i[p]) begin
                w_wr_hit[wr_addr_i[p*AW +: AW]]  = 1'b1;
                w_wr_data[wr_addr_i[p*AW +: AW]] = wr_data_i[p*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk_i or negedge n_rst) begin
        if (!n_rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_wr_hit[r]) begin
                    r_regs[r] <= w_wr_data[r];
                end
            end
        end
    end

    // Reads are combinational; reset forces zero so bypassed write data cannot leak out.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        assign w_addr = rd_addr_i[i*AW +: AW];
        always_comb begin
            if (!n_rst || (w_addr == AW'(REG_ZERO))) begin
                w_data = '0;
            end else if ((BYPASS != 0) && w_wr_hit[w_addr]) begin
                w_data = w_wr_data[w_addr];
            end else begin
                w_data = r_regs[w_addr];
            end
        end
        assign rd_data_o[i*XLEN +: XLEN] = w_data;
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .AW       (AW)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .n_rst        (n_rst),
        .i_wr_hit     (w_wr_hit),
        .i_alloc_en   (alloc_en_i),
        .i_alloc_addr (alloc_addr_i),
        .i_flush      (flush_i),
        .i_rd_addr    (rd_addr_i),
        .o_busy_vec   (busy_vec_o),
        .o_rd_busy    (rd_busy_o)
    );

endmodule
